sub_serial: RTL and testbench

- Bit-serial subtractor; the arithmetic inverse of the 4-bit ripple-carry adder.
- Computes diff = a - b - bin, one bit per clock, LSB first, using a single registered full-subtractor cell.
- Small area, multi-cycle alternative to a ripple subtract in the ALU datapath.
- Start/done handshake toward the datapath controller.

---
 rtl/sub_serial.sv | 110 +++++++++++
 tb/tb_sub_serial.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : sub_serial
// Brief    : Bit-serial subtractor, diff = a - b - bin, one bit per clock,
//            LSB first, with a start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sub_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0]    c_st_idle = 2'd0;
    localparam logic [1:0]    c_st_run  = 2'd1;
    localparam logic [1:0]    c_st_done = 2'd2;
    localparam logic [CW-1:0] c_last    = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_d;
    logic             w_br;
    logic [WIDTH-1:0] w_res_next;

    // Single full-subtractor cell operating on the current LSBs.
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br       = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_st_run;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                c_st_run: begin
                    r_res <= w_res_next;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br;
                    // Last bit: publish result directly from the shift input.
                    if (r_count == c_last) begin
                        r_diff  <= w_res_next;
                        r_bout  <= w_br;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_count <= '0;
                        r_state <= c_st_done;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_serial
// Brief    : Self-checking bench for sub_serial (WIDTH=16) against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_serial;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_diff = '0;
    logic             exp_bout = 1'b0;

    sub_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Launches an operation at the current negedge (so calling this while in
    // the DONE cycle is a back-to-back issue) and returns in the done cycle.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tbin, input bit noise);
        logic [WIDTH:0] full;
        int k;
        bit got;
        full  = {1'b0, ta} - {1'b0, tb_v} - {{WIDTH{1'b0}}, tbin};
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        k     = 0;
        got   = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                check("busy_run", busy, 1);
            end
            if (noise && k == 2) begin
                a   = WIDTH'($urandom);
                b   = WIDTH'($urandom);
                bin = ~tbin;
            end
            if (noise && k == 5) begin
                start = 1'b1;
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
            end
            if (noise && k == 6) start = 1'b0;
            if (k == 8) begin
                check("hold_diff", diff, exp_diff);
                check("hold_bout", bout, exp_bout);
            end
            if (done) got = 1;
        end
        check("latency", k, 17);
        check("busy_done", busy, 0);
        exp_diff = full[WIDTH-1:0];
        exp_bout = full[WIDTH];
        check("diff", diff, exp_diff);
        check("bout", bout, exp_bout);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int k;
        bit seen;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);

        // Directed cases
        do_op(16'h1234, 16'h0234, 1'b0, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
        do_op(16'h0000, 16'h0001, 1'b0, 0);
        @(negedge clk);
        do_op(16'h8000, 16'h7FFF, 1'b1, 0);
        @(negedge clk);

        // Mid-run start and operand changes are ignored
        do_op(16'hABCD, 16'h1357, 1'b1, 1);
        @(negedge clk);
        check("idle_hold_diff", diff, exp_diff);

        // Back-to-back: start issued in the DONE cycle
        do_op(16'h0F0F, 16'hF0F0, 1'b0, 0);
        do_op(16'h5555, 16'h5554, 1'b1, 0);
        @(negedge clk);

        // Randomized operations, mixed gaps and back-to-back
        for (int i = 0; i < 20; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            do_op(ra, rb, 1'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);

        // Abort: reset at cycle 8 of RUN
        a     = 16'h4321;
        b     = 16'h1111;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
        seen = 0;
        for (k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("abort_no_done", seen, 0);

        // Post-abort operation still works
        exp_diff = '0;
        exp_bout = 1'b0;
        do_op(16'h0100, 16'h0001, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
